multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 45 ++++
 rtl/mc_outdec.sv | 99 +++++++++
 rtl/multicycle_ctrl.sv | 84 ++++++++
 tb/tb_multicycle_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and
// the select/operation field values driven onto the datapath.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ILLEGAL = 4'd15
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic isMemOp(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-output decoder: Moore outputs per state, with the
// PC/IR enables qualified by memReady (FETCH) or the ALU zero flag (BEQEX).
module mc_outdec
  import multicycle_ctrl_pkg::*;
(
  input  stateT      state,
  input  logic       memReady,
  input  logic       zero,
  output logic       memReq,
  output logic       iOrD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       pcEn,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       illegalOp
);

  always_comb begin
    memReq    = 1'b0;
    iOrD      = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcEn      = 1'b0;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REG;
    aluOp     = ALUOP_ADD;
    pcSrc     = PCSRC_ALURES;
    illegalOp = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 and the IR load only commit on the cycle the fetch returns
        memReq  = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcEn    = memReady;
      end
      DECODE: begin
        aluSrcB = SRCB_IMMSH;
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      MEMRD: begin
        memReq = 1'b1;
        iOrD   = 1'b1;
      end
      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      MEMWR: begin
        memReq   = 1'b1;
        iOrD     = 1'b1;
        memWrite = 1'b1;
      end
      RTYPEEX: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      BEQEX: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_SUB;
        pcSrc   = PCSRC_ALUOUT;
        pcEn    = zero;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      ADDIWB: begin
        regWrite = 1'b1;
      end
      JEX: begin
        pcSrc = PCSRC_JUMP;
        pcEn  = 1'b1;
      end
      ILLEGAL: begin
        illegalOp = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: state register and next-state logic,
// with the control outputs produced by the mc_outdec decoder.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       iOrD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       pcEn,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       illegalOp,
  output logic [3:0] state
);

  stateT curState;
  stateT nextState;

  always_ff @(posedge clk) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    case (curState)
      FETCH:   if (memReady) nextState = DECODE;
      DECODE: begin
        if (isMemOp(op))          nextState = MEMADR;
        else if (op == OP_RTYPE)  nextState = RTYPEEX;
        else if (op == OP_BEQ)    nextState = BEQEX;
        else if (op == OP_ADDI)   nextState = ADDIEX;
        else if (op == OP_J)      nextState = JEX;
        else                      nextState = ILLEGAL;
      end
      MEMADR:  nextState = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memReady) nextState = MEMWB;
      MEMWB:   nextState = FETCH;
      MEMWR:   if (memReady) nextState = FETCH;
      RTYPEEX: nextState = RTYPEWB;
      RTYPEWB: nextState = FETCH;
      BEQEX:   nextState = FETCH;
      ADDIEX:  nextState = ADDIWB;
      ADDIWB:  nextState = FETCH;
      JEX:     nextState = FETCH;
      ILLEGAL: nextState = ILLEGAL;
      // codes 12-14 are not reachable legally; trap if corruption lands there
      default: nextState = ILLEGAL;
    endcase
  end

  assign state = curState;

  mc_outdec uOutdec (
    .state     (curState),
    .memReady  (memReady),
    .zero      (zero),
    .memReq    (memReq),
    .iOrD      (iOrD),
    .memWrite  (memWrite),
    .irWrite   (irWrite),
    .pcEn      (pcEn),
    .regWrite  (regWrite),
    .regDst    (regDst),
    .memToReg  (memToReg),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .pcSrc     (pcSrc),
    .illegalOp (illegalOp)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, stalls,
// the illegal trap and reset cases against hand-computed expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memReady;
  logic       memReq, iOrD, memWrite, irWrite, pcEn;
  logic       regWrite, regDst, memToReg, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic [3:0] state;

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .memReady  (memReady),
    .memReq    (memReq),
    .iOrD      (iOrD),
    .memWrite  (memWrite),
    .irWrite   (irWrite),
    .pcEn      (pcEn),
    .regWrite  (regWrite),
    .regDst    (regDst),
    .memToReg  (memToReg),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .pcSrc     (pcSrc),
    .illegalOp (illegalOp),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'b0; zero = 1'b0; memReady = 1'b0;
    tick(); tick();
    reset = 1'b0; #1;

    // reset state: FETCH decode, waiting on memory
    chk("rst_state",   state, 0);
    chk("rst_memReq",  memReq, 1);
    chk("rst_aluSrcB", aluSrcB, 2'b01);
    chk("rst_irWrite", irWrite, 0);
    chk("rst_pcEn",    pcEn, 0);
    chk("rst_illegal", illegalOp, 0);
    chk("rst_regWr",   regWrite, 0);
    memReady = 1'b1; #1;
    chk("rst_irWrite_rdy", irWrite, 1);
    chk("rst_pcEn_rdy",    pcEn, 1);

    // lw: 0 -> 1 -> 2 -> 3 -> 4 -> 0
    op = 6'b100011;
    tick(); chk("lw_s1", state, 1); chk("lw_srcB1", aluSrcB, 2'b11); chk("lw_wr1", regWrite, 0);
    tick(); chk("lw_s2", state, 2); chk("lw_srcA2", aluSrcA, 1); chk("lw_srcB2", aluSrcB, 2'b10);
    tick(); chk("lw_s3", state, 3); chk("lw_iOrD3", iOrD, 1); chk("lw_wr3", regWrite, 0);
    tick(); chk("lw_s4", state, 4); chk("lw_wr4", regWrite, 1); chk("lw_m2r4", memToReg, 1);
    chk("lw_dst4", regDst, 0);
    tick(); chk("lw_s0", state, 0); chk("lw_wr0", regWrite, 0); chk("lw_m2r0", memToReg, 0);

    // sw with three stalled cycles in MEMWR
    op = 6'b101011;
    tick(); chk("sw_s1", state, 1);
    tick(); chk("sw_s2", state, 2);
    memReady = 1'b0;
    tick(); chk("sw_s5a", state, 5); chk("sw_wr_a", memWrite, 1); chk("sw_req_a", memReq, 1);
    tick(); chk("sw_s5b", state, 5); chk("sw_wr_b", memWrite, 1);
    tick(); chk("sw_s5c", state, 5); chk("sw_wr_c", memWrite, 1);
    memReady = 1'b1; #1;
    chk("sw_wr_d", memWrite, 1); chk("sw_iOrD_d", iOrD, 1);
    tick(); chk("sw_s0", state, 0); chk("sw_wr_end", memWrite, 0);

    // beq taken
    op = 6'b000100; zero = 1'b1;
    tick(); chk("beqT_s1", state, 1);
    tick(); chk("beqT_s8", state, 8); chk("beqT_pcEn", pcEn, 1);
    chk("beqT_pcSrc", pcSrc, 2'b01); chk("beqT_aluOp", aluOp, 2'b01);
    tick(); chk("beqT_s0", state, 0);
    // beq not taken
    zero = 1'b0;
    tick(); chk("beqN_s1", state, 1);
    tick(); chk("beqN_s8", state, 8); chk("beqN_pcEn", pcEn, 0); chk("beqN_pcSrc", pcSrc, 2'b01);
    tick(); chk("beqN_s0", state, 0);

    // j
    op = 6'b000010;
    tick(); chk("j_s1", state, 1);
    tick(); chk("j_s11", state, 11); chk("j_pcEn", pcEn, 1); chk("j_pcSrc", pcSrc, 2'b10);
    tick(); chk("j_s0", state, 0);

    // R-type
    op = 6'b000000;
    tick(); chk("r_s1", state, 1);
    tick(); chk("r_s6", state, 6); chk("r_aluOp", aluOp, 2'b10); chk("r_srcB", aluSrcB, 2'b00);
    tick(); chk("r_s7", state, 7); chk("r_wr", regWrite, 1); chk("r_dst", regDst, 1);
    tick(); chk("r_s0", state, 0);

    // addi
    op = 6'b001000;
    tick(); chk("ad_s1", state, 1);
    tick(); chk("ad_s9", state, 9); chk("ad_srcB", aluSrcB, 2'b10); chk("ad_srcA", aluSrcA, 1);
    tick(); chk("ad_s10", state, 10); chk("ad_wr", regWrite, 1); chk("ad_dst", regDst, 0);
    tick(); chk("ad_s0", state, 0);

    // illegal opcode traps and holds until reset
    op = 6'b111111;
    tick(); chk("il_s1", state, 1);
    tick();
    op = 6'b100011;
    for (int i = 0; i < 10; i++) begin
      memReady = i[0];
      chk("il_hold_state", state, 15);
      chk("il_hold_flag", illegalOp, 1);
      chk("il_hold_req", memReq, 0);
      tick();
    end
    reset = 1'b1; memReady = 1'b0;
    tick();
    reset = 1'b0; #1;
    chk("il_rst_state", state, 0); chk("il_rst_flag", illegalOp, 0);

    // FETCH stall for 5 cycles, then one-cycle IR/PC load
    for (int i = 0; i < 5; i++) begin
      chk("fs_state", state, 0);
      chk("fs_irWrite", irWrite, 0);
      chk("fs_pcEn", pcEn, 0);
      tick();
    end
    memReady = 1'b1; #1;
    chk("fs_irWrite_go", irWrite, 1); chk("fs_pcEn_go", pcEn, 1);
    tick();
    chk("fs_s1", state, 1); chk("fs_irWrite_after", irWrite, 0); chk("fs_pcEn_after", pcEn, 0);

    // reset in MEMRD with memReady=1 beats the MEMWB transition
    op = 6'b100011;
    tick(); chk("rm_s2", state, 2);
    memReady = 1'b0;
    tick(); chk("rm_s3", state, 3);
    reset = 1'b1; memReady = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("rm_state", state, 0); chk("rm_regWr", regWrite, 0);
    chk("rm_memReq", memReq, 1); chk("rm_irWrite", irWrite, 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
